fsm_input_conditioner: RTL and testbench



---
 rtl/fsm_input_conditioner_pkg.sv | 14 +
 rtl/fsm_input_conditioner_if.sv | 40 ++++
 rtl/fsm_input_conditioner_debounce_cell.sv | 97 +++++++++
 rtl/fsm_input_conditioner.sv | 61 ++++++
 tb/tb_fsm_input_conditioner.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fsm_input_conditioner_pkg.sv
// Shared widths and defaults for the input conditioner and the sequence-controller FSM.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fsm_input_conditioner_pkg;

  localparam int SYNC_STAGES_DEFAULT     = 2;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

  // Button vector: bit0 -> A, bit1 -> B, bit2 -> C
  typedef logic [2:0] btn_vec_t;
  // Switch bank -> D
  typedef logic [3:0] sw_vec_t;

endpackage

// File: rtl/fsm_input_conditioner_if.sv
// Board-side raw inputs and FSM-side conditioned outputs of the input conditioner.
// Latency: n/a (wiring only).
// Backpressure: none; levels and single-cycle pulses only.
// Ports: slave = conditioner (reads raw, drives A/B/C/D and pulses);
//        master = the environment (drives raw, observes conditioned outputs).
interface fsm_input_conditioner_if;
  import fsm_input_conditioner_pkg::*;

  btn_vec_t btn_raw;
  sw_vec_t  sw_raw;
  logic     A;
  logic     B;
  logic     C;
  sw_vec_t  D;
  btn_vec_t btn_rise;
  logic     d_chg;

  modport slave (
    input  btn_raw,
    input  sw_raw,
    output A,
    output B,
    output C,
    output D,
    output btn_rise,
    output d_chg
  );

  modport master (
    output btn_raw,
    output sw_raw,
    input  A,
    input  B,
    input  C,
    input  D,
    input  btn_rise,
    input  d_chg
  );

endinterface

// File: rtl/fsm_input_conditioner_debounce_cell.sv
// Synchronise a W-bit raw vector and accept it only after DEBOUNCE_CYCLES stable cycles.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES rising edges from first sampling edge to level.
// Backpressure: none; chg/rise are one-cycle pulses aligned with the level update.
// Ports: clk, rstN (async active-low), raw[W-1:0] in; level[W-1:0], chg, rise[W-1:0] out.
module fsm_input_conditioner_debounce_cell #(
  parameter int W               = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic [W-1:0] raw,
  output logic [W-1:0] level,
  output logic         chg,
  output logic [W-1:0] rise
);

  localparam int            CW         = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ACCEPT = CW'(DEBOUNCE_CYCLES);

  logic [W-1:0]  sync_q [SYNC_STAGES];
  logic [W-1:0]  sync_d [SYNC_STAGES];
  logic [W-1:0]  sync;
  logic [W-1:0]  stable_q, stable_d;
  logic [W-1:0]  cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_next;
  logic          chg_q, chg_d;
  logic [W-1:0]  rise_q, rise_d;

  always_comb begin
    sync_d[0] = raw;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // The whole vector is compared as one value, so a multi-bit change is only
  // accepted once every bit has settled; no partial mix reaches the level.
  always_comb begin
    stable_d = stable_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    cnt_next = '0;
    chg_d    = 1'b0;
    rise_d   = '0;
    if (sync != stable_q) begin
      if (sync != cand_q) begin
        // New target: restart the qualification count.
        cand_d   = sync;
        cnt_next = CW'(1);
      end else begin
        cnt_next = cnt_q + CW'(1);
      end
      if (cnt_next == CNT_ACCEPT) begin
        // Clearing here keeps the counter bounded and makes a held input silent.
        stable_d = sync;
        cnt_d    = '0;
        chg_d    = 1'b1;
        rise_d   = sync & ~stable_q;
      end else begin
        cnt_d = cnt_next;
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      stable_q <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      chg_q    <= 1'b0;
      rise_q   <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      stable_q <= stable_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      chg_q    <= chg_d;
      rise_q   <= rise_d;
    end
  end

  assign level = stable_q;
  assign chg   = chg_q;
  assign rise  = rise_q;

endmodule

// File: rtl/fsm_input_conditioner.sv
// Synchronise and debounce board buttons/switches into A, B, C, D for the sequence FSM.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES edges per channel; pulses coincide with level change.
// Backpressure: none; every channel is independent and free-running.
// Ports: clk, rstN (async active-low); io (slave): btn_raw, sw_raw in;
//        A, B, C, D, btn_rise, d_chg out.
module fsm_input_conditioner
  import fsm_input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input logic                  clk,
  input logic                  rstN,
  fsm_input_conditioner_if.slave io
);

  btn_vec_t btn_level;
  btn_vec_t btn_rise_w;
  btn_vec_t btn_chg_unused;
  sw_vec_t  sw_level;
  sw_vec_t  sw_rise_unused;
  logic     sw_chg;

  // Buttons are qualified one bit at a time so they never wait on each other.
  for (genvar i = 0; i < 3; i++) begin : g_btn
    fsm_input_conditioner_debounce_cell #(
      .W               (1),
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cell (
      .clk   (clk),
      .rstN  (rstN),
      .raw   (io.btn_raw[i]),
      .level (btn_level[i]),
      .chg   (btn_chg_unused[i]),
      .rise  (btn_rise_w[i])
    );
  end

  // Switches are qualified as one vector so D updates atomically.
  fsm_input_conditioner_debounce_cell #(
    .W               (4),
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_cell (
    .clk   (clk),
    .rstN  (rstN),
    .raw   (io.sw_raw),
    .level (sw_level),
    .chg   (sw_chg),
    .rise  (sw_rise_unused)
  );

  assign io.A        = btn_level[0];
  assign io.B        = btn_level[1];
  assign io.C        = btn_level[2];
  assign io.D        = sw_level;
  assign io.btn_rise = btn_rise_w;
  assign io.d_chg    = sw_chg;

endmodule

// File: tb/tb_fsm_input_conditioner.sv
module tb_fsm_input_conditioner;

  localparam int SYNC = 2;
  localparam int DC   = 4;

  logic clk;
  logic rstN;

  fsm_input_conditioner_if io();

  fsm_input_conditioner #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk  (clk),
    .rstN (rstN),
    .io   (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string nm, input logic [2:0] lvl, input logic [3:0] d,
                          input logic [2:0] rise, input logic chg);
    chk({nm, ".lvl"},  {29'd0, io.C, io.B, io.A}, {29'd0, lvl});
    chk({nm, ".D"},    {28'd0, io.D},             {28'd0, d});
    chk({nm, ".rise"}, {29'd0, io.btn_rise},      {29'd0, rise});
    chk({nm, ".chg"},  {31'd0, io.d_chg},         {31'd0, chg});
  endtask

  // One rising edge, then compare on the falling edge.
  task automatic check_step(input string nm, input logic [2:0] lvl, input logic [3:0] d,
                            input logic [2:0] rise, input logic chg);
    @(posedge clk);
    @(negedge clk);
    chk_outs(nm, lvl, d, rise, chg);
  endtask

  task automatic do_reset(input logic [2:0] b, input logic [3:0] s);
    io.btn_raw = b;
    io.sw_raw  = s;
    rstN = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
  endtask

  // Reference model: a channel takes value v when the last DC synchronised
  // samples (each raw sample seen SYNC edges later) all equal v and v differs
  // from what the channel currently shows.
  logic [6:0] hist[$];
  logic [2:0] m_btn;
  logic [3:0] m_sw;
  logic [2:0] m_rise;
  logic       m_chg;

  function automatic logic [6:0] seen(input int n);
    if (n < SYNC) return 7'd0;
    return hist[n-SYNC];
  endfunction

  task automatic model_reset();
    hist.delete();
    m_btn  = '0;
    m_sw   = '0;
    m_rise = '0;
    m_chg  = 1'b0;
  endtask

  task automatic model_edge();
    int n;
    logic ok;
    logic [6:0] s;
    logic [6:0] w;
    hist.push_back({io.btn_raw, io.sw_raw});
    n = hist.size() - 1;
    s = seen(n);
    m_rise = '0;
    m_chg  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ok = 1'b1;
      for (int j = 1; j < DC; j++) begin
        w = seen(n - j);
        if (w[4+i] !== s[4+i]) ok = 1'b0;
      end
      if (ok && (s[4+i] !== m_btn[i])) begin
        m_btn[i]  = s[4+i];
        m_rise[i] = s[4+i];
      end
    end
    ok = 1'b1;
    for (int j = 1; j < DC; j++) begin
      w = seen(n - j);
      if (w[3:0] !== s[3:0]) ok = 1'b0;
    end
    if (ok && (s[3:0] !== m_sw)) begin
      m_sw  = s[3:0];
      m_chg = 1'b1;
    end
  endtask

  typedef struct {
    logic [2:0] btn;
    logic [3:0] sw;
    int         cyc;
    logic [2:0] lvl;
    logic [3:0] d;
    logic [2:0] rise;
    logic       chg;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    io.btn_raw = '0;
    io.sw_raw  = '0;
    rstN = 1'b0;

    // Table: inputs held for cyc edges, outputs checked after the last edge.
    tbl[0] = '{3'b001, 4'h0, 5, 3'b000, 4'h0, 3'b000, 1'b0};
    tbl[1] = '{3'b001, 4'h0, 1, 3'b001, 4'h0, 3'b001, 1'b0};
    tbl[2] = '{3'b000, 4'h0, 6, 3'b000, 4'h0, 3'b000, 1'b0};
    tbl[3] = '{3'b010, 4'h5, 6, 3'b010, 4'h5, 3'b010, 1'b1};
    tbl[4] = '{3'b110, 4'h5, 3, 3'b010, 4'h5, 3'b000, 1'b0};
    tbl[5] = '{3'b010, 4'h5, 6, 3'b010, 4'h5, 3'b000, 1'b0};
    tbl[6] = '{3'b111, 4'hA, 6, 3'b111, 4'hA, 3'b101, 1'b1};
    tbl[7] = '{3'b000, 4'h0, 6, 3'b000, 4'h0, 3'b000, 1'b1};

    // Reset held with all inputs active: everything stays 0.
    io.btn_raw = 3'b111;
    io.sw_raw  = 4'hF;
    repeat (3) @(negedge clk);
    chk_outs("rst_hold", 3'b000, 4'h0, 3'b000, 1'b0);
    rstN = 1'b1;
    for (int k = 1; k <= 5; k++) check_step("rst_qual", 3'b000, 4'h0, 3'b000, 1'b0);
    check_step("rst_acc", 3'b111, 4'hF, 3'b111, 1'b1);
    check_step("rst_after", 3'b111, 4'hF, 3'b000, 1'b0);

    // Table-driven vectors
    do_reset(3'b000, 4'h0);
    for (int r = 0; r < 8; r++) begin
      io.btn_raw = tbl[r].btn;
      io.sw_raw  = tbl[r].sw;
      repeat (tbl[r].cyc - 1) @(posedge clk);
      check_step($sformatf("tbl%0d", r), tbl[r].lvl, tbl[r].d, tbl[r].rise, tbl[r].chg);
    end

    // Clean press then release of A
    do_reset(3'b000, 4'h0);
    io.btn_raw = 3'b001;
    for (int k = 1; k <= 5; k++) check_step("press_wait", 3'b000, 4'h0, 3'b000, 1'b0);
    check_step("press_acc", 3'b001, 4'h0, 3'b001, 1'b0);
    check_step("press_hold", 3'b001, 4'h0, 3'b000, 1'b0);
    io.btn_raw = 3'b000;
    for (int k = 1; k <= 5; k++) check_step("rel_wait", 3'b001, 4'h0, 3'b000, 1'b0);
    check_step("rel_acc", 3'b000, 4'h0, 3'b000, 1'b0);

    // Bounce on B: 1,0,1,0 then hold 1
    do_reset(3'b000, 4'h0);
    for (int k = 0; k < 9; k++) begin
      io.btn_raw = (k < 4 && k[0]) ? 3'b000 : 3'b010;
      check_step("bounce_wait", 3'b000, 4'h0, 3'b000, 1'b0);
    end
    check_step("bounce_acc", 3'b010, 4'h0, 3'b010, 1'b0);

    // Switch transient: 9 for two cycles then 1; D must go 0 -> 1 directly
    do_reset(3'b000, 4'h0);
    io.sw_raw = 4'h9;
    check_step("sw_glitch", 3'b000, 4'h0, 3'b000, 1'b0);
    check_step("sw_glitch", 3'b000, 4'h0, 3'b000, 1'b0);
    io.sw_raw = 4'h1;
    for (int k = 3; k <= 7; k++) check_step("sw_wait", 3'b000, 4'h0, 3'b000, 1'b0);
    check_step("sw_acc", 3'b000, 4'h1, 3'b000, 1'b1);
    check_step("sw_after", 3'b000, 4'h1, 3'b000, 1'b0);

    // Simultaneous change on every channel
    do_reset(3'b000, 4'h0);
    io.btn_raw = 3'b111;
    io.sw_raw  = 4'hF;
    for (int k = 1; k <= 5; k++) check_step("sim_wait", 3'b000, 4'h0, 3'b000, 1'b0);
    check_step("sim_acc", 3'b111, 4'hF, 3'b111, 1'b1);

    // Reset in the middle of qualifying C
    do_reset(3'b000, 4'h0);
    io.btn_raw = 3'b100;
    for (int k = 1; k <= 3; k++) check_step("mid_pre", 3'b000, 4'h0, 3'b000, 1'b0);
    rstN = 1'b0;
    #1;
    chk_outs("mid_rst", 3'b000, 4'h0, 3'b000, 1'b0);
    @(negedge clk);
    rstN = 1'b1;
    for (int k = 1; k <= 5; k++) check_step("mid_requal", 3'b000, 4'h0, 3'b000, 1'b0);
    check_step("mid_acc", 3'b100, 4'h0, 3'b100, 1'b0);

    // Randomised run against the reference model, with occasional resets
    do_reset(3'b000, 4'h0);
    model_reset();
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        rstN = 1'b0;
        model_reset();
        #1;
        chk_outs("rnd_rst", m_btn, m_sw, m_rise, m_chg);
        @(negedge clk);
        rstN = 1'b1;
      end else begin
        for (int i = 0; i < 3; i++) begin
          if ($urandom_range(0, 5) == 0) io.btn_raw[i] = 1'($urandom_range(0, 1));
        end
        if ($urandom_range(0, 7) == 0) io.sw_raw = 4'($urandom_range(0, 15));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk_outs("rnd", m_btn, m_sw, m_rise, m_chg);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
